sand_sweep: RTL and testbench
=============================

# sand_sweep

Frame-sweep sequencer for the falling-sand engine. On each `start` it walks the 2-bit-per-pixel frame buffer word by word, top row to bottom row and left word to right word. For each word it fetches the word (region) and the word directly below it (floor), presents both to the combinational update unit, and writes the returned words back. It sits between the shared frame-buffer RAM port (arbitrated against VGA scan-out and CPU writes) and the update unit. One full sweep advances every grain by at most one row.

## Interface
- `COLS` default 40: words per row (640 px / 16 px per word).
- `ROWS` default 480: rows per frame.
- `ADDR_W` default 15: word-address width; must satisfy COLS*ROWS ≤ 2^ADDR_W.

- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a sweep.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when a sweep finishes.
- `mem_req` out 1: requests the RAM port; high whenever `busy`.
- `mem_gnt` in 1: RAM port granted this cycle.
- `mem_addr` out ADDR_W: word address, row*COLS+col.
- `mem_rd` out 1: read strobe; data returns on `mem_rdata` exactly 1 cycle later.
- `mem_rdata` in 32: read data.
- `mem_wr` out 1: write strobe.
- `mem_wdata` out 32: write data.
- `upd_region`, `upd_floor` out 32: registered words to the update unit.
- `upd_begin` out 1: high when col==0.
- `upd_end` out 1: high when col==COLS-1.
- `upd_bottom` out 1: high when row==ROWS-1.
- `upd_new_region`, `upd_new_floor` in 32: combinational results from the update unit.

## Operation
- Pixel encoding: AIR=00, SAND=01, SAND_AM=10, WALL=11; pixel 15 sits at bits 31:30 (leftmost).
- FSM states: IDLE, RD_R, RD_F, WAIT, CALC, WR_R, WR_F.
- IDLE: `start`=1 clears row/col and row_base, then goes to RD_R. `start` is ignored in all other states.
- RD_R: drive the region address, `mem_rd`=1.
- RD_F: `region_q <= mem_rdata`. If not the bottom row, drive the floor address (row_base+COLS+col) with `mem_rd`=1.
- WAIT: `floor_q <= mem_rdata`. In the bottom row, `floor_q <= 32'hFFFF_FFFF` (all WALL) instead.
- CALC: latch `upd_new_region`/`upd_new_floor` into nr_q/nf_q. No memory access.
- WR_R: write nr_q to the region address.
- WR_F: write nf_q to the floor address. This state is skipped in the bottom row.
- After the last write of a word, advance col. On wrap, col=0, row+1, row_base+=COLS.
- After the word at (ROWS-1, COLS-1), return to IDLE and pulse `done`.
- Handshake: RD_R, RD_F (non-bottom), WR_R and WR_F advance only in a cycle with `mem_gnt`=1. `mem_rd`/`mem_wr` are asserted only when `mem_gnt`=1; otherwise the FSM holds state and all registers.
- The bottom-row pass exists to convert leftover SAND_AM marks back to SAND. The floor write is suppressed there.
- Addresses are computed from row_base+col; no multiplier.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `mem_req`, `mem_rd`, `mem_wr` = 0; `mem_addr`, `mem_wdata`, `upd_region`, `upd_floor` = 0; all flags = 0.
- With `mem_gnt` held high:
  - 6 cycles per non-bottom word, 5 per bottom-row word.
  - Sweep length = 6*COLS*(ROWS-1) + 5*COLS cycles.
- `busy` rises the cycle after `start` is accepted. It falls in the same cycle that `done` pulses, which is the cycle after the final WR_R.
- Read-after-write ordering: the floor write of row r+1 always completes before row r+1 is read as region, so no forwarding is needed.
- `reset_n` low mid-sweep: immediate return to IDLE and outputs to reset values. A partially swept frame is acceptable.
- `upd_*` flags are registered from row/col and are stable from RD_F through WR_F of the current word.

## Structure
- Shared package `sand_pkg`:
  - pixel constants AIR/SAND/SAND_AM/WALL;
  - `pixel_t` (2-bit);
  - `sweep_state_t` enum;
  - `WALL_WORD` = 32'hFFFF_FFFF.
- One sub-module, `sand_addr_gen`: row/col/row_base counters, the advance and wrap logic, and generation of region address, floor address and flags. The FSM and data registers live in `sand_sweep`.

## Test plan
Bench uses COLS=2, ROWS=3, the real update unit, a 1-cycle-latency RAM model, and `mem_gnt`=1 unless stated.
- Cycle count: `start` with an all-AIR frame -> `busy` high for exactly 34 cycles, then a single `done` pulse; RAM contents unchanged.
- Single grain fall: word(0,0)=32'h0000_0400 -> after sweep 1, word(0,0)=0 and word(1,0)=32'h0000_0400. After sweep 2, word(2,0)=32'h0000_0400.
- Bottom cleanup: word(2,1)=32'h0000_0008 -> after one sweep, 32'h0000_0004. No write is ever issued to an address ≥6.
- Grant stall: `mem_gnt` toggles 1,0,0,1 repeatedly -> the final RAM contents match the no-stall run, and `mem_rd`/`mem_wr` are never high while `mem_gnt`=0.
- Flags: `upd_begin` is high only for col 0, `upd_end` only for col 1, `upd_bottom` only for row 2. `start` pulsed while `busy` -> ignored; exactly one `done` pulse.
- Reset mid-sweep: `reset_n` low in cycle 10 -> all outputs at reset values the same cycle; a new `start` then completes a normal 34-cycle sweep.

Source files
------------

// File: rtl/sand_pkg.sv
// Shared definitions for the falling-sand frame sweep: pixel codes and
// the sweep sequencer state encoding.
package sand_pkg;

  typedef logic [1:0] pixel_t;

  localparam pixel_t AIR     = 2'b00;
  localparam pixel_t SAND    = 2'b01;
  localparam pixel_t SAND_AM = 2'b10;
  localparam pixel_t WALL    = 2'b11;

  localparam logic [31:0] WALL_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_R = 3'd1,
    RD_F = 3'd2,
    WAIT = 3'd3,
    CALC = 3'd4,
    WR_R = 3'd5,
    WR_F = 3'd6
  } sweep_state_t;

endpackage

// File: rtl/sand_addr_gen.sv
// Row/column walker for the frame sweep: counters, wrap logic, word
// addresses of the region and floor words, and registered position flags.
module sand_addr_gen
  import sand_pkg::*;
#(
  parameter int COLS   = 40,
  parameter int ROWS   = 480,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_region_addr,
  output logic [ADDR_W-1:0] o_floor_addr,
  output logic              o_last,
  output logic              o_begin,
  output logic              o_end,
  output logic              o_bottom
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic              w_col_last;
  logic              w_row_last;

  assign w_col_last    = (r_col == CW'(COLS - 1));
  assign w_row_last    = (r_row == RW'(ROWS - 1));
  assign o_last        = w_col_last && w_row_last;
  // row_base tracks row*COLS incrementally so no multiplier is needed
  assign o_region_addr = r_row_base + ADDR_W'(r_col);
  assign o_floor_addr  = r_row_base + COLS_A + ADDR_W'(r_col);

  // Position counters: cleared on sweep start, stepped after each word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (i_clear) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (i_adv) begin
      if (w_col_last) begin
        r_col      <= '0;
        r_row      <= r_row + RW'(1);
        r_row_base <= r_row_base + COLS_A;
      end else begin
        r_col      <= r_col + CW'(1);
      end
    end
  end

  // Position flags registered from the counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_begin  <= 1'b0;
      o_end    <= 1'b0;
      o_bottom <= 1'b0;
    end else begin
      o_begin  <= (r_col == CW'(0));
      o_end    <= w_col_last;
      o_bottom <= w_row_last;
    end
  end

endmodule

// File: rtl/sand_sweep.sv
// Frame-sweep sequencer: reads each region word and the floor word below,
// hands both to the update unit, and writes the results back.
module sand_sweep
  import sand_pkg::*;
#(
  parameter int COLS   = 40,
  parameter int ROWS   = 480,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       upd_region,
  output logic [31:0]       upd_floor,
  output logic              upd_begin,
  output logic              upd_end,
  output logic              upd_bottom,
  input  logic [31:0]       upd_new_region,
  input  logic [31:0]       upd_new_floor
);

  sweep_state_t      r_state;
  sweep_state_t      w_next;
  logic              r_rd_q;
  logic              r_done;
  logic [31:0]       r_region;
  logic [31:0]       r_floor;
  logic [31:0]       r_nr;
  logic [31:0]       r_nf;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_adv;
  logic              w_clear;
  logic              w_done_set;
  logic [ADDR_W-1:0] w_region_addr;
  logic [ADDR_W-1:0] w_floor_addr;
  logic              w_last;

  sand_addr_gen #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (w_clear),
    .i_adv        (w_adv),
    .o_region_addr(w_region_addr),
    .o_floor_addr (w_floor_addr),
    .o_last       (w_last),
    .o_begin      (upd_begin),
    .o_end        (upd_end),
    .o_bottom     (upd_bottom)
  );

  // Next-state and memory strobes; strobes only fire in granted cycles
  always_comb begin
    w_next     = r_state;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_addr     = '0;
    w_wdata    = 32'h0000_0000;
    w_adv      = 1'b0;
    w_clear    = 1'b0;
    w_done_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = RD_R;
        end else begin
          w_next  = IDLE;
        end
      end
      RD_R: begin
        w_addr = w_region_addr;
        if (mem_gnt) begin
          w_rd   = 1'b1;
          w_next = RD_F;
        end else begin
          w_next = RD_R;
        end
      end
      RD_F: begin
        if (upd_bottom) begin
          w_next = WAIT;
        end else begin
          w_addr = w_floor_addr;
          if (mem_gnt) begin
            w_rd   = 1'b1;
            w_next = WAIT;
          end else begin
            w_next = RD_F;
          end
        end
      end
      WAIT: w_next = CALC;
      CALC: w_next = WR_R;
      WR_R: begin
        w_addr  = w_region_addr;
        w_wdata = r_nr;
        if (mem_gnt) begin
          w_wr = 1'b1;
          if (!upd_bottom) begin
            w_next = WR_F;
          end else if (w_last) begin
            w_done_set = 1'b1;
            w_next     = IDLE;
          end else begin
            w_adv  = 1'b1;
            w_next = RD_R;
          end
        end else begin
          w_next = WR_R;
        end
      end
      WR_F: begin
        w_addr  = w_floor_addr;
        w_wdata = r_nf;
        if (mem_gnt) begin
          w_wr   = 1'b1;
          w_adv  = 1'b1;
          w_next = RD_R;
        end else begin
          w_next = WR_F;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_rd_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_set;
      r_rd_q  <= w_rd;
    end
  end

  // Data capture; region is taken only in the cycle its read returns,
  // so a stalled RD_F does not pick up another master's data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_region <= 32'h0000_0000;
      r_floor  <= 32'h0000_0000;
      r_nr     <= 32'h0000_0000;
      r_nf     <= 32'h0000_0000;
    end else begin
      if (r_state == RD_F && r_rd_q) r_region <= mem_rdata;
      if (r_state == WAIT) r_floor <= upd_bottom ? WALL_WORD : mem_rdata;
      if (r_state == CALC) begin
        r_nr <= upd_new_region;
        r_nf <= upd_new_floor;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign mem_req    = busy;
  assign done       = r_done;
  assign mem_rd     = w_rd;
  assign mem_wr     = w_wr;
  assign mem_addr   = w_addr;
  assign mem_wdata  = w_wdata;
  assign upd_region = r_region;
  assign upd_floor  = r_floor;

endmodule

// File: tb/tb_sand_sweep.sv
// Scoreboard bench for sand_sweep on a 2x3-word frame with a 1-cycle RAM
// model, a behavioural update unit and a frame-level reference sweep.
module tb_sand_sweep;
  import sand_pkg::*;

  localparam int C  = 2;
  localparam int R  = 3;
  localparam int AW = 4;
  localparam int N  = C * R;
  localparam int LEN = 6 * C * (R - 1) + 5 * C;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          mem_gnt = 1'b1;
  logic          busy, done, mem_req, mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = 32'h0;
  logic [31:0]   mem_wdata, upd_region, upd_floor;
  logic          upd_begin, upd_end, upd_bottom;
  logic [31:0]   upd_new_region, upd_new_floor;

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic [2:0]  flags;
  } wr_t;

  wr_t         wq[$];
  int          dq[$];
  int          errors = 0;
  int          checks = 0;
  int          dones = 0;
  int          busy_cnt = 0;
  int          gnt_mode = 0;
  int          gcyc = 0;
  logic [31:0] ram[0:15];
  logic [31:0] model[0:N-1];
  logic [31:0] saved[0:N-1];

  sand_sweep #(.COLS(C), .ROWS(R), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .upd_region(upd_region), .upd_floor(upd_floor), .upd_begin(upd_begin),
    .upd_end(upd_end), .upd_bottom(upd_bottom),
    .upd_new_region(upd_new_region), .upd_new_floor(upd_new_floor)
  );

  always #5 clk = ~clk;

  // Update unit: marked grains become plain sand; sand over air falls and is marked
  function automatic logic [63:0] upd_fn(input logic [31:0] rw, input logic [31:0] fw);
    logic [31:0] nr, nf;
    logic [1:0]  p, q;
    nr = rw;
    nf = fw;
    for (int i = 0; i < 16; i++) begin
      p = rw[2*i +: 2];
      q = fw[2*i +: 2];
      if (p == SAND_AM) nr[2*i +: 2] = SAND;
      else if (p == SAND && q == AIR) begin
        nr[2*i +: 2] = AIR;
        nf[2*i +: 2] = SAND_AM;
      end
    end
    return {nr, nf};
  endfunction

  assign {upd_new_region, upd_new_floor} = upd_fn(upd_region, upd_floor);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM model: writes land at the edge, read data appears the next cycle,
  // garbage otherwise
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? ram[mem_addr] : $urandom;
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (gnt_mode)
        1:       mem_gnt = (gcyc % 4 == 0) || (gcyc % 4 == 3);
        2:       mem_gnt = 1'($urandom_range(0, 1));
        default: mem_gnt = 1'b1;
      endcase
      gcyc++;
    end
  end

  // Monitor: pops expected writes / sweep completions as the DUT presents them
  always @(negedge clk) begin : monitor
    wr_t e;
    int  l;
    if (reset_n) begin
      chk("mem_req_eq_busy", mem_req, busy);
      if (mem_rd || mem_wr) chk("strobe_needs_gnt", mem_gnt, 1);
      if (mem_wr) begin
        chk("wr_addr_range", mem_addr < AW'(N), 1);
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0h, none expected", mem_addr, mem_wdata);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_flags", {upd_begin, upd_end, upd_bottom}, e.flags);
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        dones++;
        chk("busy_low_at_done", busy, 0);
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done, none expected");
        end else begin
          l = dq.pop_front();
          if (l >= 0) chk("sweep_len", busy_cnt, l);
        end
        busy_cnt = 0;
      end
    end
  end

  // Reference sweep over the whole frame; queues the writes it implies
  task automatic push_sweep(input int len);
    int a;
    logic [31:0] rw, fw, nr, nf;
    wr_t w;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        a  = r * C + c;
        rw = model[a];
        fw = (r == R - 1) ? WALL_WORD : model[a + C];
        {nr, nf} = upd_fn(rw, fw);
        w.flags = {c == 0, c == C - 1, r == R - 1};
        model[a] = nr;
        w.addr = a;
        w.data = nr;
        wq.push_back(w);
        if (r != R - 1) begin
          model[a + C] = nf;
          w.addr = a + C;
          w.data = nf;
          wq.push_back(w);
        end
      end
    end
    dq.push_back(len);
  endtask

  task automatic load(input int kind);
    logic [31:0] v;
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    for (int i = 0; i < N; i++) begin
      v = (kind == 1) ? $urandom : 32'h0;
      ram[i] = v;
      model[i] = v;
    end
  endtask

  task automatic run_sweep(input int len, input bit extra_start);
    int d0;
    d0 = dones;
    push_sweep(len);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    if (extra_start) begin
      repeat (7) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
    end
    for (int k = 0; k < 2000 && dones == d0; k++) @(negedge clk);
    chk("sweep_finished", dones > d0, 1);
    repeat (8) @(negedge clk);
    chk("single_done", dones - d0, 1);
    chk("writes_drained", wq.size(), 0);
    for (int i = 0; i < N; i++) chk("ram_vs_model", ram[i], model[i]);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {busy, done, mem_req, mem_rd, mem_wr, upd_begin, upd_end, upd_bottom}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_upd_words", {upd_region, upd_floor}, 0);
    #1 reset_n = 1'b1;

    // all-air frame: exact length, contents unchanged
    load(0);
    run_sweep(LEN, 1'b0);
    for (int i = 0; i < N; i++) chk("air_unchanged", ram[i], 32'h0);

    // single grain falls one row per sweep
    load(0);
    ram[0] = 32'h0000_0400; model[0] = 32'h0000_0400;
    run_sweep(LEN, 1'b0);
    chk("grain_s1_w00", ram[0], 32'h0);
    chk("grain_s1_w10", ram[2], 32'h0000_0400);
    run_sweep(LEN, 1'b0);
    chk("grain_s2_w20", ram[4], 32'h0000_0400);

    // bottom-row mark cleanup
    load(0);
    ram[5] = 32'h0000_0008; model[5] = 32'h0000_0008;
    run_sweep(LEN, 1'b0);
    chk("bottom_cleanup", ram[5], 32'h0000_0004);

    // stalled run must match the unstalled one; start while busy ignored
    load(1);
    for (int i = 0; i < N; i++) saved[i] = ram[i];
    run_sweep(LEN, 1'b1);
    for (int i = 0; i < N; i++) begin
      ram[i] = saved[i];
      saved[i] = model[i];
      model[i] = ram[i];
    end
    gnt_mode = 1;
    gcyc = 0;
    run_sweep(-1, 1'b0);
    for (int i = 0; i < N; i++) chk("stall_matches", ram[i], saved[i]);

    // random frames under random grant
    gnt_mode = 2;
    for (int t = 0; t < 4; t++) begin
      load(1);
      run_sweep(-1, 1'b0);
    end
    gnt_mode = 0;

    // reset mid-sweep, then a clean sweep
    load(1);
    push_sweep(-1);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_flags", {busy, done, mem_req, mem_rd, mem_wr, upd_begin, upd_end, upd_bottom}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_upd_words", {upd_region, upd_floor}, 0);
    wq.delete();
    dq.delete();
    busy_cnt = 0;
    @(posedge clk); #2 reset_n = 1'b1;
    for (int i = 0; i < N; i++) model[i] = ram[i];
    run_sweep(LEN, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
